// File: rtl/alu_arbiter.sv
// Purpose : two-requester round-robin arbiter in front of one shared, op-transparent ALU.
// Latency : response valid 2 cycles after accept; back-to-back issue every 3 cycles minimum.
// Backpr. : one op in flight; req readys stay low until the owner's response is consumed.
//
// Ports   : clk/reset (sync, active-low); req{0,1}_valid/ready/op/src0/src1 request side;
//           rsp{0,1}_valid/ready + shared rsp_result/rsp_zero response side;
//           alu_op/alu_src0/alu_src1 registered drive to the ALU, alu_result/alu_zero back;
//           busy high whenever the FSM is not idle.
// Config  : define ALU_ARBITER_FIXED_PRIO_EN to make requester 0 win every tie.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [3:0]   req0_op,
    input  logic [3:0]   req1_op,
    input  logic [N-1:0] req0_src0,
    input  logic [N-1:0] req0_src1,
    input  logic [N-1:0] req1_src0,
    input  logic [N-1:0] req1_src1,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    input  logic         rsp0_ready,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero,
    output logic [N-1:0] alu_src0,
    output logic [N-1:0] alu_src1,
    output logic [3:0]   alu_op,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;   // requester granted most recently
    logic   owner;        // requester whose op is in flight
    logic   grant0;
    logic   grant1;
    logic   rsp_take;

    // Requester 1 wins only when it is alone, or on a tie when 0 went last.
    always_comb begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        grant1 = req1_valid && !req0_valid;
`else
        grant1 = req1_valid && (!req0_valid || !last_grant);
`endif
        grant0 = req0_valid && !grant1;
    end

    // Handshake outputs are gated by reset so they read 0 during reset
    // even though the state register only clears at the edge.
    assign req0_ready = reset && (state == IDLE) && grant0;
    assign req1_ready = reset && (state == IDLE) && grant1;
    assign rsp0_valid = reset && (state == RESP) && !owner;
    assign rsp1_valid = reset && (state == RESP) && owner;
    assign busy       = reset && (state != IDLE);

    // Only the owner's ready can complete the response.
    assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            alu_op     <= '0;
            alu_src0   <= '0;
            alu_src1   <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_op     <= grant1 ? req1_op   : req0_op;
                        alu_src0   <= grant1 ? req1_src0 : req0_src0;
                        alu_src1   <= grant1 ? req1_src1 : req0_src1;
                        owner      <= grant1;
                        last_grant <= grant1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU operands have been stable for a full cycle here.
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = '0, req1_op = '0;
    logic [N-1:0] req0_src0 = '0, req0_src1 = '0, req1_src0 = '0, req1_src1 = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;
    logic [N-1:0] alu_src0, alu_src1;
    logic [3:0]   alu_op;
    logic [N-1:0] alu_result;
    logic         alu_zero;
    logic         busy;

    // Stub ALU: add, zero flag.
    assign alu_result = alu_src0 + alu_src1;
    assign alu_zero   = (alu_result == '0);

    alu_arbiter #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_src0(req0_src0), .req0_src1(req0_src1),
        .req1_src0(req1_src0), .req1_src1(req1_src1),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard entry: what the owner must eventually see.
    typedef struct {
        logic         owner;
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         zero;
    } exp_t;
    exp_t sb[$];

    // Transaction-level model: one op outstanding at a time, age in edges since accept.
    bit m_out = 0;
    bit m_last = 1;
    int m_age = 0;

    bit mon_en = 0;
    bit rst_at_edge = 0;
    bit acc0 = 0, acc1 = 0;

    always @(posedge clk) begin
        mon_en      <= 1'b1;
        rst_at_edge <= !reset;
    end

    // Monitor / model step, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (reset !== 1'b1) begin
                chk("reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 64'd0);
                if (rst_at_edge)
                    chk("reset_regs", {63'd0, |{alu_op, alu_src0, alu_src1, rsp_result, rsp_zero}}, 64'd0);
                // In-flight op is discarded; nothing may ever answer it.
                sb.delete();
                m_out  = 0;
                m_last = 1;
                m_age  = 0;
                acc0   = 0;
                acc1   = 0;
            end else begin
                bit g, er0, er1, ev;
                exp_t e;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
                g = (req0_valid && req1_valid) ? 1'b0 : req1_valid;
`else
                g = (req0_valid && req1_valid) ? !m_last : req1_valid;
`endif
                er0 = !m_out && req0_valid && !g;
                er1 = !m_out && req1_valid && g;
                chk("req_ready", {62'd0, req0_ready, req1_ready}, {62'd0, er0, er1});
                chk("busy", {63'd0, busy}, {63'd0, m_out});
                ev = m_out && (m_age >= 1);
                chk("rsp_valid", {62'd0, rsp0_valid, rsp1_valid},
                    {62'd0, ev && (sb[0].owner == 1'b0), ev && (sb[0].owner == 1'b1)});
                if (m_out) begin
                    chk("alu_op", {60'd0, alu_op}, {60'd0, sb[0].op});
                    chk("alu_srcs", {alu_src0, alu_src1}, {sb[0].a, sb[0].b});
                end
                if (ev) begin
                    chk("rsp_result", {32'd0, rsp_result}, {32'd0, sb[0].res});
                    chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, sb[0].zero});
                end
                acc0 = req0_valid && req0_ready;
                acc1 = req1_valid && req1_ready;
                if (!m_out) begin
                    if (er0 || er1) begin
                        e.owner = g;
                        e.op    = g ? req1_op   : req0_op;
                        e.a     = g ? req1_src0 : req0_src0;
                        e.b     = g ? req1_src1 : req0_src1;
                        e.res   = e.a + e.b;
                        e.zero  = (e.res == 0);
                        sb.push_back(e);
                        m_last = g;
                        m_out  = 1;
                        m_age  = 0;
                    end
                end else if (ev && (sb[0].owner ? rsp1_ready : rsp0_ready)) begin
                    void'(sb.pop_front());
                    m_out = 0;
                end else begin
                    m_age++;
                end
            end
        end
    end

    // Drive helpers: inputs change 1 time unit after the rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [N-1:0] a, input logic [N-1:0] b);
        if (i == 0) begin
            req0_valid = v; req0_op = op; req0_src0 = a; req0_src1 = b;
        end else begin
            req1_valid = v; req1_op = op; req1_src0 = a; req1_src1 = b;
        end
    endtask

    task automatic issue(input int i, input logic [3:0] op,
                         input logic [N-1:0] a, input logic [N-1:0] b);
        bit done = 0;
        set_req(i, 1'b1, op, a, b);
        for (int k = 0; k < 30 && !done; k++) begin
            @(posedge clk);
            done = (i == 0) ? acc0 : acc1;
        end
        #1;
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        set_req(i, 1'b0, op, a, b);
    endtask

    initial begin
        int grants;
        bit done;
        cyc(3);
        reset = 1'b1;
        cyc(1);

        // Single op from requester 0: 5 + 7.
        issue(0, 4'h3, 32'h0000_0005, 32'h0000_0007);
        cyc(4);

        // Wrap-around to zero from requester 1.
        issue(1, 4'h9, 32'hFFFF_FFFF, 32'h0000_0001);
        cyc(4);

        // Both requesters continuously valid: alternation checked by the model.
        set_req(0, 1'b1, 4'h1, $urandom, $urandom);
        set_req(1, 1'b1, 4'h2, $urandom, $urandom);
        grants = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            if (acc0) begin set_req(0, 1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom); grants++; end
            if (acc1) begin set_req(1, 1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom); grants++; end
        end
        chk("issue_rate", 64'(grants), 64'd8);
        set_req(0, 1'b0, 4'h0, '0, '0);
        set_req(1, 1'b0, 4'h0, '0, '0);
        cyc(4);

        // Owner stalls the response while requester 1 waits.
        rsp0_ready = 1'b0;
        issue(0, 4'h5, 32'h1234_0000, 32'h0000_5678);
        set_req(1, 1'b1, 4'h6, 32'h0000_0010, 32'h0000_0020);
        cyc(7);
        rsp0_ready = 1'b1;
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(posedge clk);
            done = acc1;
        end
        #1;
        if (!done) chk("stall_req1_timeout", 64'd0, 64'd1);
        set_req(1, 1'b0, 4'h0, '0, '0);
        cyc(4);

        // Reset pulse while the op is executing.
        issue(0, 4'hA, 32'h0000_0100, 32'h0000_0200);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(3);
        issue(1, 4'hB, 32'h0000_0003, 32'h0000_0004);
        cyc(4);

        // Randomized traffic with random backpressure and rare resets.
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 149) != 0);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            if (req0_valid ? acc0 : ($urandom_range(0, 2) == 0))
                set_req(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            if (req1_valid ? acc1 : ($urandom_range(0, 2) == 0))
                set_req(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
        end

        reset = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(0, 1'b0, 4'h0, '0, '0);
        set_req(1, 1'b0, 4'h0, '0, '0);
        cyc(8);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = in reset).
REQ-004 SHALL have ports req0_valid, req1_valid  input  1 each  requester i has an operation pending.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1 each  operation from requester i accepted this cycle.
REQ-006 SHALL have ports req0_op, req1_op  input  4 each  ALU op code, passed through unmodified.
REQ-007 SHALL have ports req0_src0, req0_src1, req1_src0, req1_src1  input  N each  operands.
REQ-008 SHALL have ports rsp0_valid, rsp1_valid  output  1 each  result available for requester i.
REQ-009 SHALL have ports rsp0_ready, rsp1_ready  input  1 each  requester i consumes result.
REQ-010 SHALL have ports rsp_result  output  N  and rsp_zero  output  1  shared response data.
REQ-011 SHALL have ports alu_src0, alu_src1  output  N, alu_op  output  4  registered drive to the shared ALU.
REQ-012 SHALL have ports alu_result  input  N, alu_zero  input  1  combinational ALU outputs.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other transitions except reset.
REQ-015 In IDLE, SHALL assert exactly one reqi_ready, for the granted requester, only when its reqi_valid is high; both readys low in EXEC/RESP.
REQ-016 Grant: one valid -> that requester; both valid -> requester not granted last (round-robin); none -> no grant.
REQ-017 On reqi_valid && reqi_ready at edge E0, SHALL latch op/src0/src1 into alu_op/alu_src0/alu_src1, record owner i, enter EXEC, update last-grant to i.
REQ-018 alu_* outputs SHALL hold last latched values in all states until next accept.
REQ-019 At edge E1 (end of EXEC), SHALL register alu_result/alu_zero into rsp_result/rsp_zero and enter RESP.
REQ-020 In RESP, SHALL assert rsp{owner}_valid only; rsp_result/rsp_zero stable until transfer.
REQ-021 Transfer on rsp{owner}_valid && rsp{owner}_ready; next state IDLE; non-owner rspj_ready ignored.
REQ-022 Latency: rsp valid first visible the cycle after E1 (2 cycles after accept); min issue interval 3 cycles.
REQ-023 Requesters SHALL hold valid/op/src stable until ready; arbiter need not tolerate withdrawal.
REQ-024 Arbiter SHALL be op-transparent: no decoding of op, no modification of operands or results.

Reset
REQ-025 While reset==0 at an edge: state IDLE, last-grant=1 (req0 wins first tie), alu_op=0, alu_src0=0, alu_src1=0, rsp_result=0, rsp_zero=0.
REQ-026 While reset==0: req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy SHALL all be 0.
REQ-027 Reset in EXEC or RESP SHALL discard the in-flight operation; no response is ever produced for it.

Configuration
REQ-028 Macro ALU_ARBITER_FIXED_PRIO_EN: defined -> grant on tie always to requester 0 (last-grant unused); undefined -> round-robin per REQ-016.

Verification (bench uses stub ALU: result=src0+src1, zero=(result==0))
REQ-029 Single req0 (op=4'h3, src0=0x00000005, src1=0x00000007) -> req0_ready same cycle, rsp0_valid 2 cycles later, rsp_result=0x0000000C, rsp_zero=0, alu_op=4'h3.
REQ-030 Both valid continuously, rsp ready always high -> grants alternate 0,1,0,1 (round-robin) or 0,0,0 (FIXED_PRIO_EN defined); one accept per 3 cycles.
REQ-031 req1 src0=0xFFFFFFFF, src1=0x00000001 -> rsp_result=0x00000000, rsp_zero=1, only rsp1_valid high.
REQ-032 rsp0_ready held low 5 cycles in RESP -> rsp0_valid and rsp_result stable 5 cycles, busy=1, both req readys 0, new req1 waits.
REQ-033 reset=0 for one cycle during EXEC -> next cycle all outputs at reset values, no rsp_valid ever for that op, next req accepted normally.
